// File: rtl/mul_ifft_frame_buf_if.sv
// Bus bundle between mul_ip, the ping-pong frame buffer and the IFFT stage.
// Signal names keep the buffer-side direction suffixes of the original ports.
interface mul_ifft_frame_buf_if #(
    parameter int DW = 32,
    parameter int SW = 2
);
    // Product stream from mul_ip
    logic          mul_ready_i;
    logic [DW-1:0] x_re_i;
    logic [DW-1:0] x_im_i;
    logic          dl_busy_o;
    logic          overrun_o;
    // Frame stream to the IFFT
    logic          ifft_ready_i;
    logic          ifft_start_o;
    logic          ifft_valid_o;
    logic          ifft_last_o;
    logic [DW-1:0] y_re_o;
    logic [DW-1:0] y_im_o;
    logic [SW-1:0] scale_idx_o;

    // Frame buffer side
    modport slave (
        input  mul_ready_i, x_re_i, x_im_i, ifft_ready_i,
        output dl_busy_o, overrun_o, ifft_start_o, ifft_valid_o, ifft_last_o,
               y_re_o, y_im_o, scale_idx_o
    );

    // Producer / consumer side
    modport master (
        output mul_ready_i, x_re_i, x_im_i, ifft_ready_i,
        input  dl_busy_o, overrun_o, ifft_start_o, ifft_valid_o, ifft_last_o,
               y_re_o, y_im_o, scale_idx_o
    );
endinterface

// File: rtl/mul_ifft_frame_buf.sv
// Ping-pong frame buffer between mul_ip and the inverse-FFT stage.
// Two banks of N complex words; one is filled by mul_ip while the other is
// replayed to the IFFT, optionally in bit-reversed order.
module mul_ifft_frame_buf #(
    parameter int N      = 256,
    parameter int J1     = 4,
    parameter int DW     = 32,
    parameter int BITREV = 1
) (
    input logic                 clk,
    input logic                 rstn,
    mul_ifft_frame_buf_if.slave bus
);
    localparam int LOG2N = $clog2(N);
    localparam int SW    = (J1 > 1) ? $clog2(J1) : 1;
    localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(N - 1);
    localparam logic [SW-1:0]    LAST_SCL  = SW'(J1 - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2
    } state_e;

    // Read address for stream index k: bit-reversed or natural order
    function automatic logic [LOG2N-1:0] rd_addr_f(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        r = k;
        if (BITREV != 0) begin
            for (int unsigned b = 0; b < LOG2N; b++) begin
                r[b] = k[LOG2N-1-b];
            end
        end
        return r;
    endfunction

    logic [2*DW-1:0]  mem_q [0:2*N-1];
    logic [2*DW-1:0]  y_q;

    state_e           state_q, state_d;
    logic [LOG2N-1:0] k_q, k_d;
    logic             rd_bank_q, rd_bank_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             dl_busy_q, dl_busy_d;
    logic             overrun_q, overrun_d;
    logic [SW-1:0]    scale_q, scale_d;

    logic             wr_en, wr_last;
    logic             rd_en, rd_last;
    logic [LOG2N-1:0] rd_idx;
    logic [LOG2N:0]   rd_addr;
    logic             ifft_start, ifft_valid, ifft_last;

    // Read FSM: next state, read issue and stream strobes
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ifft_start = 1'b0;
        ifft_valid = 1'b0;
        ifft_last  = 1'b0;
        rd_en      = 1'b0;
        rd_last    = 1'b0;
        rd_idx     = '0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q] && bus.ifft_ready_i) begin
                    state_d = START;
                end
            end
            START: begin
                ifft_start = 1'b1;
                rd_en      = 1'b1;
                rd_idx     = '0;
                k_d        = '0;
                state_d    = STREAM;
            end
            STREAM: begin
                ifft_valid = 1'b1;
                if (k_q == LAST_IDX) begin
                    ifft_last = 1'b1;
                    rd_last   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rd_en  = 1'b1;
                    rd_idx = k_q + 1'b1;
                    k_d    = k_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_addr = {rd_bank_q, rd_addr_f(rd_idx)};

    // Bank bookkeeping: write pointer, full flags, busy/overrun, scale counter
    always_comb begin
        wr_en     = bus.mul_ready_i & ~dl_busy_q;
        wr_last   = wr_en & (wr_cnt_q == LAST_IDX);
        wr_cnt_d  = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d = wr_last ? ~wr_bank_q : wr_bank_q;
        rd_bank_d = rd_last ? ~rd_bank_q : rd_bank_q;
        scale_d   = scale_q;
        full_d    = full_q;
        if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
        end
        // A frame is only written into a free bank, so the read bank being
        // released is never the one being completed on the same edge.
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
            scale_d = (scale_q == LAST_SCL) ? '0 : scale_q + 1'b1;
        end
        dl_busy_d = full_d[wr_bank_d];
        overrun_d = overrun_q | (bus.mul_ready_i & dl_busy_q);
    end

    // Control state registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            k_q       <= '0;
            rd_bank_q <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            full_q    <= '0;
            dl_busy_q <= 1'b0;
            overrun_q <= 1'b0;
            scale_q   <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_bank_q <= rd_bank_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            full_q    <= full_d;
            dl_busy_q <= dl_busy_d;
            overrun_q <= overrun_d;
            scale_q   <= scale_d;
        end
    end

    // Sample storage write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, wr_cnt_q}] <= {bus.x_re_i, bus.x_im_i};
        end
    end

    // Synchronous read; the register only loads on issued reads so it holds between frames
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_q <= '0;
        end else if (rd_en) begin
            y_q <= mem_q[rd_addr];
        end
    end

    assign bus.dl_busy_o    = dl_busy_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.ifft_start_o = ifft_start;
    assign bus.ifft_valid_o = ifft_valid;
    assign bus.ifft_last_o  = ifft_last;
    assign bus.y_re_o       = y_q[2*DW-1:DW];
    assign bus.y_im_o       = y_q[DW-1:0];
    assign bus.scale_idx_o  = scale_q;
endmodule

// File: tb/tb_mul_ifft_frame_buf.sv
// Scoreboard bench for the ping-pong IFFT frame buffer.
module tb_mul_ifft_frame_buf;
    localparam int N      = 256;
    localparam int J1     = 4;
    localparam int DW     = 32;
    localparam int BITREV = 1;
    localparam int SW     = 2;
    localparam int LOG2N  = $clog2(N);

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
        int unsigned   scale;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    mul_ifft_frame_buf_if #(.DW(DW), .SW(SW)) bus ();

    mul_ifft_frame_buf #(.N(N), .J1(J1), .DW(DW), .BITREV(BITREV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   bad   = 0;

    exp_t exp_q[$];
    int   done_q[$];
    logic [DW-1:0] cur_re [N];
    logic [DW-1:0] cur_im [N];
    int   wr_n      = 0;
    int   frames_wr = 0;
    int   wr_done   = 0;
    int   rd_done   = 0;
    bit   ovr_m     = 0;
    int   prev_last = -1000;
    int   ready_on  = 0;
    int   start_cyc = 0;
    bit   in_frame  = 0;
    bit   prev_start = 0;
    logic [DW-1:0] hold_re = '0;
    logic [DW-1:0] hold_im = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic int unsigned rev(input int unsigned k);
        int unsigned r;
        if (BITREV == 0) return k;
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = (r << 1) | ((k >> b) & 1);
        return r;
    endfunction

    // Reference: an accepted sample lands in the current frame; a full frame
    // is queued in replay order with its scale number.
    task automatic model_write(input logic [DW-1:0] re, input logic [DW-1:0] im, input int c);
        exp_t e;
        cur_re[wr_n] = re;
        cur_im[wr_n] = im;
        wr_n++;
        if (wr_n == N) begin
            for (int k = 0; k < N; k++) begin
                e.re    = cur_re[rev(k)];
                e.im    = cur_im[rev(k)];
                e.last  = (k == N - 1);
                e.scale = frames_wr % J1;
                exp_q.push_back(e);
            end
            frames_wr++;
            wr_done++;
            done_q.push_back(c);
            wr_n = 0;
        end
    endtask

    // One clock of the write side, entered and left at posedge+1
    task automatic step(input bit v, input logic [DW-1:0] re, input logic [DW-1:0] im);
        bit busy_m;
        int c;
        busy_m = (wr_done - rd_done) >= 2;
        chk("dl_busy", 64'(bus.dl_busy_o), 64'(busy_m));
        bus.mul_ready_i = v;
        bus.x_re_i      = re;
        bus.x_im_i      = im;
        c = cyc;
        @(posedge clk);
        if (v) begin
            if (busy_m) ovr_m = 1;
            else        model_write(re, im, c);
        end
        #1;
        bus.mul_ready_i = 1'b0;
    endtask

    // Behaves like mul_ip: holds off while the buffer reports busy
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int n;
        n = 0;
        while ((wr_done - rd_done) >= 2 && n < 3000) begin
            step(0, $urandom, $urandom);
            n++;
        end
        chk("busy_wait_bound", 64'(n < 3000), 64'(1));
        step(1, re, im);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < 3000) begin
            step(0, $urandom, $urandom);
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'(0));
        step(0, $urandom, $urandom);
    endtask

    task automatic chk_zero();
        chk("rst_start", 64'(bus.ifft_start_o), 64'(0));
        chk("rst_valid", 64'(bus.ifft_valid_o), 64'(0));
        chk("rst_last",  64'(bus.ifft_last_o),  64'(0));
        chk("rst_y_re",  64'(bus.y_re_o),       64'(0));
        chk("rst_y_im",  64'(bus.y_im_o),       64'(0));
        chk("rst_scale", 64'(bus.scale_idx_o),  64'(0));
        chk("rst_busy",  64'(bus.dl_busy_o),    64'(0));
        chk("rst_ovr",   64'(bus.overrun_o),    64'(0));
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        chk_zero();
        @(posedge clk);
        exp_q.delete();
        done_q.delete();
        wr_n      = 0;
        frames_wr = 0;
        wr_done   = 0;
        rd_done   = 0;
        ovr_m     = 0;
        prev_last = -1000;
        hold_re   = '0;
        hold_im   = '0;
        @(negedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every valid sample and checks framing
    always @(negedge clk) begin
        exp_t e;
        int   es;
        if (!rstn) begin
            in_frame   = 0;
            prev_start = 0;
        end else begin
            if (prev_start) chk("valid_after_start", 64'(bus.ifft_valid_o), 64'(1));
            prev_start = bus.ifft_start_o;
            if (bus.ifft_start_o) begin
                chk("start_has_frame", 64'(done_q.size() > 0), 64'(1));
                chk("start_not_in_frame", 64'(in_frame), 64'(0));
                chk("start_valid_low", 64'(bus.ifft_valid_o), 64'(0));
                if (done_q.size() > 0) begin
                    es = done_q[0] + 2;
                    if (prev_last + 2 > es) es = prev_last + 2;
                    if (ready_on + 1 > es)  es = ready_on + 1;
                    chk("start_cycle", 64'(cyc), 64'(es));
                    void'(done_q.pop_front());
                end
                if (exp_q.size() > 0) chk("start_scale", 64'(bus.scale_idx_o), 64'(exp_q[0].scale));
                in_frame  = 1;
                start_cyc = cyc;
            end
            if (bus.ifft_valid_o) begin
                chk("valid_in_frame", 64'(in_frame), 64'(1));
                if (exp_q.size() == 0) begin
                    chk("sample_expected", 64'(bus.ifft_valid_o), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("y_re",  64'(bus.y_re_o),      64'(e.re));
                    chk("y_im",  64'(bus.y_im_o),      64'(e.im));
                    chk("last",  64'(bus.ifft_last_o), 64'(e.last));
                    chk("scale", 64'(bus.scale_idx_o), 64'(e.scale));
                    if (e.last) begin
                        in_frame  = 0;
                        prev_last = cyc;
                        rd_done++;
                    end
                end
                hold_re = bus.y_re_o;
                hold_im = bus.y_im_o;
            end else begin
                chk("last_low",  64'(bus.ifft_last_o), 64'(0));
                chk("y_hold_re", 64'(bus.y_re_o), 64'(hold_re));
                chk("y_hold_im", 64'(bus.y_im_o), 64'(hold_im));
                if (in_frame && !bus.ifft_start_o) chk("no_gap", 64'(bus.ifft_valid_o), 64'(1));
            end
            chk("overrun", 64'(bus.overrun_o), 64'(ovr_m));
        end
    end

    initial begin
        int n;
        bus.mul_ready_i  = 1'b0;
        bus.x_re_i       = '0;
        bus.x_im_i       = '0;
        bus.ifft_ready_i = 1'b0;
        #1;
        do_reset();

        // Ramp frame, bit-reversed replay
        bus.ifft_ready_i = 1'b1;
        ready_on = cyc;
        for (int i = 0; i < N; i++) send(DW'(i), DW'(-i));
        drain();

        // Two frames held back by the IFFT, then dropped samples
        bus.ifft_ready_i = 1'b0;
        for (int i = 0; i < 2 * N; i++) send($urandom, $urandom);
        for (int i = 0; i < 3; i++) step(1, $urandom, $urandom);
        bus.ifft_ready_i = 1'b1;
        ready_on = cyc;
        drain();

        // Five frames with random producer gaps; scale wraps
        do_reset();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) step(0, $urandom, $urandom);
                send($urandom, $urandom);
            end
        end
        drain();

        // Next frame completes on the edge the current frame's last sample leaves
        for (int i = 0; i < N; i++) send($urandom, $urandom);
        step(0, $urandom, $urandom);
        step(0, $urandom, $urandom);
        for (int i = 0; i < N; i++) send($urandom, $urandom);
        drain();

        // Reset in mid-stream discards everything
        for (int i = 0; i < N; i++) send($urandom, $urandom);
        n = 0;
        while (!in_frame && n < 1000) begin
            step(0, $urandom, $urandom);
            n++;
        end
        chk("stream_began", 64'(in_frame), 64'(1));
        while (cyc < start_cyc + 101) step(0, $urandom, $urandom);
        @(negedge clk);
        #1;
        do_reset();
        for (int i = 0; i < N - 1; i++) send($urandom, $urandom);
        for (int i = 0; i < 20; i++) step(0, $urandom, $urandom);
        send($urandom, $urandom);
        drain();

        chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
